// File: rtl/serial_master_port.sv
// Requester end of the req/gnt/frame bus: queues one command, wins the bus, sends one bit-serial frame.
// Optional read timeout is enabled by defining SMP_TIMEOUT_EN.
module serial_master_port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int TMO_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              frame_active_o,
  output logic              tx_bit_o,
  output logic              tx_valid_o,
  input  logic              rx_bit_i,
  input  logic              rx_valid_i
);
  localparam int HDR_W   = ADDR_W + 1;
  localparam int FRM_W   = HDR_W + DATA_W;
  localparam int CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

  if (DATA_W < 2 || TMO_W < 2) begin : g_param_chk
    $error("serial_master_port: DATA_W and TMO_W must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_WDAT, S_RDAT, S_DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRM_W-1:0]  sh_q;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rdata_q;
  logic              we_q, cmd_ready_q, req_q, frame_q, tx_valid_q, rsp_valid_q, rsp_err_q;
  logic              in_frame, abort, data_done, tmo_hit, fin;

`ifdef SMP_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] tmo_q;

  // Held at zero outside RDAT so every read starts a fresh wait window.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != S_RDAT || rx_valid_i) tmo_q <= '0;
    else                                          tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = gnt_i && (state_q == S_RDAT) && !rx_valid_i && (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign cnt_d     = cnt_q + 1'b1;
  assign rx_sh_d   = {rx_sh_q[DATA_W-2:0], rx_bit_i};
  assign in_frame  = (state_q == S_HDR) || (state_q == S_WDAT) || (state_q == S_RDAT);
  assign abort     = in_frame && !gnt_i;
  assign data_done = gnt_i && (cnt_q == DAT_LAST) &&
                     ((state_q == S_WDAT) || (state_q == S_RDAT && rx_valid_i));
  assign fin       = abort || data_done || tmo_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      rx_sh_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      req_q       <= 1'b0;
      frame_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (fin) begin
        // Any frame exit (normal, grant loss, timeout) funnels through DONE.
        state_q     <= S_DONE;
        req_q       <= 1'b0;
        frame_q     <= 1'b0;
        tx_valid_q  <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !data_done;
        if (data_done && state_q == S_RDAT) rdata_q <= rx_sh_d;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cmd_ready_q <= 1'b1;
            if (cmd_valid_i && cmd_ready_q) begin
              sh_q        <= {cmd_we_i, cmd_addr_i, cmd_wdata_i};
              we_q        <= cmd_we_i;
              cmd_ready_q <= 1'b0;
              req_q       <= 1'b1;
              state_q     <= S_REQ;
            end
          end
          S_REQ: begin
            if (gnt_i) begin
              state_q    <= S_HDR;
              frame_q    <= 1'b1;
              tx_valid_q <= 1'b1;
              cnt_q      <= '0;
            end
          end
          S_HDR: begin
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_d;
            if (cnt_q == HDR_LAST) begin
              cnt_q      <= '0;
              tx_valid_q <= we_q;
              state_q    <= we_q ? S_WDAT : S_RDAT;
            end
          end
          S_WDAT: begin
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_d;
          end
          S_RDAT: begin
            if (rx_valid_i) begin
              rx_sh_q <= rx_sh_d;
              cnt_q   <= cnt_d;
            end
          end
          S_DONE: begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = rsp_err_q;
  assign req_o          = req_q;
  assign frame_active_o = frame_q;
  assign tx_valid_o     = tx_valid_q;
  assign tx_bit_o       = tx_valid_q & sh_q[FRM_W-1];
endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port: directed vector table, hand sequences for reset/timeout, random transactions.
module tb_serial_master_port;
  localparam int AW = 16, DW = 8, TW = 4;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_we, gnt, rx_bit, rx_valid;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic cmd_ready_o, rsp_valid_o, rsp_err_o, req_o, frame_active_o, tx_bit_o, tx_valid_o;
  logic [DW-1:0] rsp_rdata_o;

  int n_pass = 0, n_chk = 0;

  always #5 clk = ~clk;

  serial_master_port #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .req_o(req_o), .gnt_i(gnt), .frame_active_o(frame_active_o),
    .tx_bit_o(tx_bit_o), .tx_valid_o(tx_valid_o), .rx_bit_i(rx_bit), .rx_valid_i(rx_valid)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          gdly;
    logic [7:0]  rbyte;
    logic [31:0] gap;
    int          drop;
    logic        silent;
  } txn_t;

  typedef struct {
    logic        rsp;
    logic        err;
    logic [7:0]  rdata;
    int          frames;
    int          ntx;
    logic [24:0] tx;
    int          reqonly;
    int          rdybusy;
    int          reqlowf;
    logic        req_rsp;
    logic        after_ok;
  } res_t;

  typedef struct { txn_t t; res_t e; } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Expected outcome from the frame rules: bit stream {we,addr,wdata}, frame lengths, timeout window.
  function automatic res_t model(input txn_t t, input logic [7:0] prev);
    res_t r;
    logic [24:0] full;
    int sil, nb;
    logic v;
    r = '{rsp:1'b1, err:1'b0, rdata:prev, frames:-1, ntx:0, tx:'0, reqonly:t.gdly + 1,
          rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b1};
    full = {t.we, t.addr, t.wd};
    sil = 0;
    nb  = 0;
    if (t.we) begin
      if (t.drop >= 1 && t.drop <= 25) begin r.frames = t.drop; r.err = 1'b1; end
      else r.frames = 25;
    end else if (t.drop >= 1 && t.drop <= 17) begin
      r.frames = t.drop;
      r.err    = 1'b1;
    end else begin
      for (int k = 0; k < 200; k++) begin
        if (t.drop == 18 + k) begin r.frames = 18 + k; r.err = 1'b1; break; end
        v = (k < 32) ? !t.gap[k] : !t.silent;
        if (v) begin
          nb++;
          sil = 0;
          if (nb == 8) begin r.frames = 18 + k; r.rdata = t.rbyte; break; end
        end else begin
          sil++;
`ifdef SMP_TIMEOUT_EN
          if (sil == 15) begin r.frames = 18 + k; r.err = 1'b1; break; end
`endif
        end
      end
      if (r.frames < 0) r.rsp = 1'b0;
    end
    r.ntx = t.we ? r.frames : ((r.frames < 17) ? r.frames : 17);
    if (r.ntx < 0) r.ntx = 0;
    r.tx = full >> (25 - r.ntx);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; acts as master core, arbiter and responder.
  task automatic run_txn(input txn_t t, input int limit, input logic junk, output res_t o);
    int ridx, nbit, reqcnt, cyc;
    o = '{rsp:1'b0, err:1'b0, rdata:'0, frames:0, ntx:0, tx:'0, reqonly:0,
          rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b0};
    ridx = 0; nbit = 0; reqcnt = 0; cyc = 0;
    cmd_we = t.we; cmd_addr = t.addr; cmd_wdata = t.wd; cmd_valid = 1'b1;
    while (!cmd_ready_o && cyc < limit) begin
      gnt = junk & 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    gnt = junk & 1'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (cyc < limit) begin
      if (rsp_valid_o) begin
        o.rsp = 1'b1; o.err = rsp_err_o; o.rdata = rsp_rdata_o;
        o.req_rsp = req_o | frame_active_o;
        cmd_valid = 1'b0; gnt = 1'b0; rx_valid = 1'b0;
        break;
      end
      if (cmd_ready_o) o.rdybusy++;
      if (req_o && !frame_active_o) o.reqonly++;
      if (frame_active_o) begin
        o.frames++;
        if (!req_o) o.reqlowf++;
        if (tx_valid_o) begin o.tx = {o.tx[23:0], tx_bit_o}; o.ntx++; end
      end
      if (req_o) reqcnt++;
      if (!req_o) gnt = junk & 1'($urandom);
      else if (!frame_active_o) gnt = (reqcnt > t.gdly);
      if (frame_active_o && o.frames == t.drop) gnt = 1'b0;
      if (frame_active_o && !tx_valid_o) begin
        rx_valid = (ridx < 32) ? !t.gap[ridx] : !t.silent;
        rx_bit   = (rx_valid && nbit < 8) ? t.rbyte[7 - nbit] : 1'($urandom);
        if (rx_valid) nbit++;
        ridx++;
      end else begin
        rx_valid = junk & 1'($urandom);
        rx_bit   = 1'($urandom);
      end
      if (junk) cmd_valid = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    if (o.rsp) begin
      @(negedge clk);
      o.after_ok = !rsp_valid_o && cmd_ready_o && !req_o && !frame_active_o;
      @(negedge clk);
      o.after_ok = o.after_ok && !req_o && !rsp_valid_o;
    end
  endtask

  task automatic cmp(input string tg, input res_t o, input res_t e);
    chk({tg, " rsp"}, 32'(o.rsp), 32'(e.rsp));
    if (e.rsp) begin
      chk({tg, " err"}, 32'(o.err), 32'(e.err));
      chk({tg, " rdata"}, 32'(o.rdata), 32'(e.rdata));
      chk({tg, " frame_len"}, o.frames, e.frames);
      chk({tg, " tx_count"}, o.ntx, e.ntx);
      chk({tg, " tx_bits"}, 32'(o.tx), 32'(e.tx));
      chk({tg, " req_cycles"}, o.reqonly, e.reqonly);
      chk({tg, " ready_busy"}, o.rdybusy, e.rdybusy);
      chk({tg, " req_in_frame"}, o.reqlowf, e.reqlowf);
      chk({tg, " req_at_done"}, 32'(o.req_rsp), 32'(e.req_rsp));
      chk({tg, " back_idle"}, 32'(o.after_ok), 32'(e.after_ok));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    res_t o, e;
    txn_t t;
    logic [7:0] last_rd;
    int fc, cyc;
    logic seen;

    vt[0].t = '{we:1'b1, addr:16'h1234, wd:8'hA5, gdly:1, rbyte:8'h00, gap:32'h0, drop:0, silent:1'b0};
    vt[0].e = '{rsp:1'b1, err:1'b0, rdata:8'h00, frames:25, ntx:25, tx:25'h11234A5, reqonly:2,
                rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b1};
    vt[1].t = '{we:1'b0, addr:16'h00F0, wd:8'h00, gdly:0, rbyte:8'h3C, gap:32'h18, drop:0, silent:1'b0};
    vt[1].e = '{rsp:1'b1, err:1'b0, rdata:8'h3C, frames:27, ntx:17, tx:25'h00000F0, reqonly:1,
                rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b1};
    vt[2].t = '{we:1'b1, addr:16'hBEEF, wd:8'h5A, gdly:20, rbyte:8'h00, gap:32'h0, drop:0, silent:1'b0};
    vt[2].e = '{rsp:1'b1, err:1'b0, rdata:8'h3C, frames:25, ntx:25, tx:25'h1BEEF5A, reqonly:21,
                rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b1};
    vt[3].t = '{we:1'b1, addr:16'hCAFE, wd:8'h11, gdly:2, rbyte:8'h00, gap:32'h0, drop:7, silent:1'b0};
    vt[3].e = '{rsp:1'b1, err:1'b1, rdata:8'h3C, frames:7, ntx:7, tx:25'h0000072, reqonly:3,
                rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b1};
    vt[4].t = '{we:1'b0, addr:16'h8001, wd:8'h00, gdly:0, rbyte:8'hC3, gap:32'h0, drop:20, silent:1'b0};
    vt[4].e = '{rsp:1'b1, err:1'b1, rdata:8'h3C, frames:20, ntx:17, tx:25'h0008001, reqonly:1,
                rdybusy:0, reqlowf:0, req_rsp:1'b0, after_ok:1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    gnt = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {25'b0, cmd_ready_o, rsp_valid_o, rsp_err_o, req_o, frame_active_o, tx_valid_o, tx_bit_o}, 32'h0);
    chk("reset rdata", 32'(rsp_rdata_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle ready", {30'b0, cmd_ready_o, req_o}, 32'h2);

    foreach (vt[i]) begin
      run_txn(vt[i].t, 200, 1'b1, o);
      cmp($sformatf("vec%0d", i), o, vt[i].e);
    end
    last_rd = 8'h3C;

    // Reset in the middle of the write payload.
    cmd_we = 1'b1; cmd_addr = 16'h0F0F; cmd_wdata = 8'h99; cmd_valid = 1'b1; gnt = 1'b0;
    cyc = 0;
    while (!cmd_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    cmd_valid = 1'b0; gnt = 1'b1;
    fc = 0; cyc = 0;
    while (fc < 20 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (frame_active_o) fc++;
    end
    chk("midwdat reached", {31'b0, tx_valid_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst outputs", {25'b0, cmd_ready_o, rsp_valid_o, rsp_err_o, req_o, frame_active_o, tx_valid_o, tx_bit_o}, 32'h0);
    chk("midrst rdata", 32'(rsp_rdata_o), 32'h0);
    rst = 1'b0; gnt = 1'b0; seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rsp_valid_o | req_o | frame_active_o;
    end
    chk("midrst quiet", 32'(seen), 32'h0);
    last_rd = 8'h00;
    t = '{we:1'b0, addr:16'h5A5A, wd:8'h00, gdly:1, rbyte:8'h96, gap:32'h5, drop:0, silent:1'b0};
    e = model(t, last_rd);
    run_txn(t, 200, 1'b1, o);
    cmp("post_rst", o, e);
    last_rd = e.rdata;

    for (int n = 0; n < 40; n++) begin
      t.we     = 1'($urandom);
      t.addr   = 16'($urandom);
      t.wd     = 8'($urandom);
      t.gdly   = $urandom_range(0, 3);
      t.rbyte  = 8'($urandom);
      t.gap    = $urandom & $urandom & $urandom;
      t.drop   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      t.silent = 1'b0;
      e = model(t, last_rd);
      run_txn(t, 200, 1'b1, o);
      cmp($sformatf("rnd%0d", n), o, e);
      last_rd = e.rdata;
    end

    // Read where the responder never answers.
    t = '{we:1'b0, addr:16'h0042, wd:8'h00, gdly:0, rbyte:8'hFF, gap:32'hFFFF_FFFF, drop:0, silent:1'b1};
`ifdef SMP_TIMEOUT_EN
    e = model(t, last_rd);
    run_txn(t, 200, 1'b0, o);
    cmp("timeout", o, e);
    chk("timeout len", o.frames, 32);
`else
    run_txn(t, 120, 1'b0, o);
    chk("no_tmo rsp", 32'(o.rsp), 32'h0);
    chk("no_tmo frame", {31'b0, frame_active_o}, 32'h1);
    chk("no_tmo waited", 32'(o.frames >= 100), 32'h1);
    rst = 1'b1; gnt = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
